flist_arb: RTL and testbench

- Round-robin arbiter that shares one free-list allocator (alloc/dealloc handshake, id width WIDTH) between NCLI client ports.
- Sits between the client engines (e.g. linked-list FIFO queues) and the free-list.
- Serialises requests, holds the dealloc id stable until the allocator acks, and routes each ack and allocated id back to the correct client.
- Alloc and dealloc paths are independent and run concurrently.

---
 rtl/flist_arb_pkg.sv | 21 ++
 rtl/flist_arb_rr_arb.sv | 31 +++
 rtl/flist_arb.sv | 188 ++++++++++++++++++
 tb/tb_flist_arb.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/flist_arb_pkg.sv
// Shared types, defaults and helpers for the free-list arbiter.
package flist_arb_pkg;

  localparam int unsigned NCLI_DEF  = 4;
  localparam int unsigned WIDTH_DEF = 16;
  localparam int unsigned QUOTA_DEF = 64;

  typedef enum logic [1:0] {A_IDLE, A_ISSUE, A_WAIT, A_HOLD} a_state_t;
  typedef enum logic [1:0] {D_IDLE, D_ISSUE, D_WAIT, D_HOLD} d_state_t;

  // Ceiling log2; returns 0 for v <= 1.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((64'(1) << i) < 64'(v)) r = 32'(i + 1);
    end
    return r;
  endfunction

endpackage

// File: rtl/flist_arb_rr_arb.sv
// Combinational round-robin pick: first requester at or above ptr, with wrap.
module rr_arb
  import flist_arb_pkg::*;
#(
  parameter  int unsigned NCLI = NCLI_DEF,
  localparam int unsigned IW   = clog2(NCLI)
) (
  input  logic [NCLI-1:0] req,
  input  logic [IW-1:0]   ptr,
  output logic [IW-1:0]   gnt_c,
  output logic            vld_c
);

  int idx;

  // Scan farthest offset first so the nearest requester wins the last write.
  always_comb begin
    gnt_c = '0;
    vld_c = 1'b0;
    idx   = 0;
    for (int k = int'(NCLI) - 1; k >= 0; k--) begin
      idx = int'(ptr) + k;
      if (idx >= int'(NCLI)) idx = idx - int'(NCLI);
      if (req[IW'(idx)]) begin
        gnt_c = IW'(idx);
        vld_c = 1'b1;
      end
    end
  end

endmodule

// File: rtl/flist_arb.sv
// Round-robin sharing of one free-list allocator between NCLI clients.
// Optional per-client outstanding-id quota: define FLIST_ARB_QUOTA_EN.
module flist_arb
  import flist_arb_pkg::*;
#(
  parameter int unsigned NCLI  = NCLI_DEF,
  parameter int unsigned WIDTH = WIDTH_DEF,
  parameter int unsigned QUOTA = QUOTA_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NCLI-1:0]       cli_alloc_req,
  output logic [NCLI-1:0]       cli_alloc_ack,
  output logic [WIDTH-1:0]      cli_alloc_id,
  input  logic [NCLI-1:0]       cli_dealloc_req,
  input  logic [NCLI*WIDTH-1:0] cli_dealloc_id,
  output logic [NCLI-1:0]       cli_dealloc_ack,
  input  logic                  fl_init_done,
  output logic                  fl_alloc_req,
  input  logic                  fl_alloc_ack,
  input  logic [WIDTH-1:0]      fl_alloc_id,
  output logic                  fl_dealloc_req,
  output logic [WIDTH-1:0]      fl_dealloc_id,
  input  logic                  fl_dealloc_ack,
  output logic                  busy
`ifdef FLIST_ARB_QUOTA_EN
  ,
  output logic                  quota_err
`endif
);

  localparam int unsigned IW = clog2(NCLI);

  if (NCLI < 2 || NCLI > 16 || QUOTA < 1) begin : g_bad_param
    $error("flist_arb: NCLI or QUOTA out of range");
  end

  a_state_t         a_st;
  d_state_t         d_st;
  logic [IW-1:0]    a_g, a_ptr, a_gnt_c;
  logic [IW-1:0]    d_g, d_ptr, d_gnt_c;
  logic             a_vld_c, d_vld_c;
  logic             a_go_c, d_go_c;
  logic             a_busy_nx_c, d_busy_nx_c;
  logic [NCLI-1:0]  a_elig_c;
  logic [WIDTH-1:0] dl_id [NCLI];

  for (genvar i = 0; i < NCLI; i++) begin : g_dl_slice
    assign dl_id[i] = cli_dealloc_id[i*WIDTH +: WIDTH];
  end

`ifdef FLIST_ARB_QUOTA_EN
  localparam int unsigned QW = clog2(QUOTA + 1);

  logic [QW-1:0] q_cnt [NCLI];

  // Outstanding-id count per client; freeing at zero is forwarded but flagged.
  always_ff @(posedge clk or negedge rst_n) begin : p_quota
    if (!rst_n) begin
      for (int i = 0; i < int'(NCLI); i++) q_cnt[i] <= '0;
      quota_err <= 1'b0;
    end else begin
      for (int i = 0; i < int'(NCLI); i++) begin
        if (cli_alloc_ack[i] && !cli_dealloc_ack[i]) begin
          q_cnt[i] <= q_cnt[i] + QW'(1);
        end else if (!cli_alloc_ack[i] && cli_dealloc_ack[i]) begin
          if (q_cnt[i] == '0) quota_err <= 1'b1;
          else                q_cnt[i]  <= q_cnt[i] - QW'(1);
        end
      end
    end
  end

  always_comb begin
    a_elig_c = '0;
    for (int i = 0; i < int'(NCLI); i++) begin
      a_elig_c[i] = cli_alloc_req[i] && (q_cnt[i] != QW'(QUOTA));
    end
  end
`else
  assign a_elig_c = cli_alloc_req;
`endif

  rr_arb #(.NCLI(NCLI)) u_rr_alloc (
    .req   (a_elig_c),
    .ptr   (a_ptr),
    .gnt_c (a_gnt_c),
    .vld_c (a_vld_c)
  );

  rr_arb #(.NCLI(NCLI)) u_rr_dealloc (
    .req   (cli_dealloc_req),
    .ptr   (d_ptr),
    .gnt_c (d_gnt_c),
    .vld_c (d_vld_c)
  );

  assign a_go_c = fl_init_done && a_vld_c;
  assign d_go_c = fl_init_done && d_vld_c;

  // Alloc path: grant, pulse allocator, wait for id, present ack for one cycle.
  always_ff @(posedge clk or negedge rst_n) begin : p_alloc_fsm
    if (!rst_n) begin
      a_st          <= A_IDLE;
      a_g           <= '0;
      a_ptr         <= '0;
      fl_alloc_req  <= 1'b0;
      cli_alloc_ack <= '0;
      cli_alloc_id  <= '0;
    end else begin
      case (a_st)
        A_IDLE: begin
          if (a_go_c) begin
            a_g          <= a_gnt_c;
            fl_alloc_req <= 1'b1;
            a_st         <= A_ISSUE;
          end
        end
        A_ISSUE: begin
          fl_alloc_req <= 1'b0;
          a_st         <= A_WAIT;
        end
        A_WAIT: begin
          if (fl_alloc_ack) begin
            cli_alloc_id  <= fl_alloc_id;
            cli_alloc_ack <= NCLI'(1) << a_g;
            a_ptr         <= (a_g == IW'(NCLI - 1)) ? '0 : a_g + IW'(1);
            a_st          <= A_HOLD;
          end
        end
        A_HOLD: begin
          cli_alloc_ack <= '0;
          a_st          <= A_IDLE;
        end
        default: a_st <= A_IDLE;
      endcase
    end
  end

  // Dealloc path: same shape; the freed id is captured at grant and held.
  always_ff @(posedge clk or negedge rst_n) begin : p_dealloc_fsm
    if (!rst_n) begin
      d_st            <= D_IDLE;
      d_g             <= '0;
      d_ptr           <= '0;
      fl_dealloc_req  <= 1'b0;
      fl_dealloc_id   <= '0;
      cli_dealloc_ack <= '0;
    end else begin
      case (d_st)
        D_IDLE: begin
          if (d_go_c) begin
            d_g            <= d_gnt_c;
            fl_dealloc_id  <= dl_id[d_gnt_c];
            fl_dealloc_req <= 1'b1;
            d_st           <= D_ISSUE;
          end
        end
        D_ISSUE: begin
          fl_dealloc_req <= 1'b0;
          d_st           <= D_WAIT;
        end
        D_WAIT: begin
          if (fl_dealloc_ack) begin
            cli_dealloc_ack <= NCLI'(1) << d_g;
            d_ptr           <= (d_g == IW'(NCLI - 1)) ? '0 : d_g + IW'(1);
            d_st            <= D_HOLD;
          end
        end
        D_HOLD: begin
          cli_dealloc_ack <= '0;
          d_st            <= D_IDLE;
        end
        default: d_st <= D_IDLE;
      endcase
    end
  end

  // busy tracks "state after this edge is not idle" so it stays a flop output.
  assign a_busy_nx_c = (a_st == A_IDLE) ? a_go_c : (a_st != A_HOLD);
  assign d_busy_nx_c = (d_st == D_IDLE) ? d_go_c : (d_st != D_HOLD);

  always_ff @(posedge clk or negedge rst_n) begin : p_busy
    if (!rst_n) busy <= 1'b0;
    else        busy <= a_busy_nx_c || d_busy_nx_c;
  end

endmodule

// File: tb/tb_flist_arb.sv
// Self-checking bench for flist_arb with a 256-entry free-list allocator model.
module tb_flist_arb;
  import flist_arb_pkg::*;

  localparam int unsigned NCLI   = 4;
  localparam int unsigned WIDTH  = 16;
  localparam int unsigned QUOTA  = 2;
  localparam int          FL_LAT = 2;

  logic                  clk;
  logic                  rst_n;
  logic [NCLI-1:0]       cli_alloc_req;
  logic [NCLI-1:0]       cli_alloc_ack;
  logic [WIDTH-1:0]      cli_alloc_id;
  logic [NCLI-1:0]       cli_dealloc_req;
  logic [NCLI*WIDTH-1:0] cli_dealloc_id;
  logic [NCLI-1:0]       cli_dealloc_ack;
  logic                  fl_init_done;
  logic                  fl_alloc_req;
  logic                  fl_alloc_ack;
  logic [WIDTH-1:0]      fl_alloc_id;
  logic                  fl_dealloc_req;
  logic [WIDTH-1:0]      fl_dealloc_id;
  logic                  fl_dealloc_ack;
  logic                  busy;
`ifdef FLIST_ARB_QUOTA_EN
  logic                  quota_err;
`endif

  flist_arb #(.NCLI(NCLI), .WIDTH(WIDTH), .QUOTA(QUOTA)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .cli_alloc_req   (cli_alloc_req),
    .cli_alloc_ack   (cli_alloc_ack),
    .cli_alloc_id    (cli_alloc_id),
    .cli_dealloc_req (cli_dealloc_req),
    .cli_dealloc_id  (cli_dealloc_id),
    .cli_dealloc_ack (cli_dealloc_ack),
    .fl_init_done    (fl_init_done),
    .fl_alloc_req    (fl_alloc_req),
    .fl_alloc_ack    (fl_alloc_ack),
    .fl_alloc_id     (fl_alloc_id),
    .fl_dealloc_req  (fl_dealloc_req),
    .fl_dealloc_id   (fl_dealloc_id),
    .fl_dealloc_ack  (fl_dealloc_ack),
    .busy            (busy)
`ifdef FLIST_ARB_QUOTA_EN
    ,
    .quota_err       (quota_err)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Allocator model: ids 0..255 in order; ack registered FL_LAT cycles after req is sampled.
  logic [WIDTH-1:0] fl_mem [512];
  logic [8:0]       fl_head, fl_tail;
  logic [FL_LAT:0]  a_pipe, d_pipe;

  assign fl_alloc_ack   = a_pipe[FL_LAT];
  assign fl_dealloc_ack = d_pipe[FL_LAT];
  assign fl_alloc_id    = fl_mem[fl_head];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 256; i++) fl_mem[i] <= WIDTH'(i);
      fl_head <= 9'd0;
      fl_tail <= 9'd256;
      a_pipe  <= '0;
      d_pipe  <= '0;
    end else begin
      a_pipe <= {a_pipe[FL_LAT-1:0], fl_alloc_req};
      d_pipe <= {d_pipe[FL_LAT-1:0], fl_dealloc_req};
      if (fl_alloc_ack) fl_head <= fl_head + 9'd1;
      if (fl_dealloc_ack) begin
        fl_mem[fl_tail] <= fl_dealloc_id;
        fl_tail         <= fl_tail + 9'd1;
      end
    end
  end

  typedef struct { int cli; int id; } a_exp_t;

  a_exp_t a_exp [$];
  int     d_exp [$];
  int     d_ack_cnt [NCLI];
  int     last_dl_id;
  int     n_chk;
  int     n_err;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b1;
    #1;
    rst_n           = 1'b0;
    fl_init_done    = 1'b0;
    cli_alloc_req   = '0;
    cli_dealloc_req = '0;
    a_exp.delete();
    d_exp.delete();
    foreach (d_ack_cnt[i]) d_ack_cnt[i] = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((a_exp.size() != 0 || d_exp.size() != 0 || busy) && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (n >= 300) check("idle_timeout", 1, 0);
    @(negedge clk);
  endtask

  task automatic req_alloc(input int c, input int id);
    a_exp.push_back('{cli: c, id: id});
    cli_alloc_req[c] = 1'b1;
  endtask

  task automatic req_free(input int c, input int id);
    d_exp.push_back(c);
    cli_dealloc_id[c*WIDTH +: WIDTH] = WIDTH'(id);
    cli_dealloc_req[c] = 1'b1;
  endtask

  task automatic check_all_zero(input string pfx);
    check({pfx, "_alloc_ack"}, 32'(cli_alloc_ack), 0);
    check({pfx, "_alloc_id"}, 32'(cli_alloc_id), 0);
    check({pfx, "_dl_ack"}, 32'(cli_dealloc_ack), 0);
    check({pfx, "_fl_alloc_req"}, 32'(fl_alloc_req), 0);
    check({pfx, "_fl_dl_req"}, 32'(fl_dealloc_req), 0);
    check({pfx, "_fl_dl_id"}, 32'(fl_dealloc_id), 0);
    check({pfx, "_busy"}, 32'(busy), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int  lat;
    logic seen, stable, ovl;
    n_chk = 0;
    n_err = 0;
    last_dl_id = -1;
    cli_dealloc_id = '0;
    fl_init_done = 1'b0;
    cli_alloc_req = '0;
    cli_dealloc_req = '0;

    // Scoreboard: pop expected results as acks appear; clients drop req on ack.
    fork
      forever begin
        a_exp_t e;
        int     c;
        @(negedge clk);
        if (rst_n && fl_dealloc_ack) last_dl_id = int'(fl_dealloc_id);
        if (rst_n && cli_alloc_ack != '0) begin
          if (a_exp.size() == 0) check("alloc_unexpected", 32'(cli_alloc_ack), 0);
          else begin
            e = a_exp.pop_front();
            check("alloc_ack", 32'(cli_alloc_ack), 32'(1) << e.cli);
            check("alloc_id", 32'(cli_alloc_id), 32'(e.id));
          end
          cli_alloc_req = cli_alloc_req & ~cli_alloc_ack;
        end
        if (rst_n && cli_dealloc_ack != '0) begin
          for (int i = 0; i < int'(NCLI); i++) if (cli_dealloc_ack[i]) d_ack_cnt[i]++;
          if (d_exp.size() == 0) check("dl_unexpected", 32'(cli_dealloc_ack), 0);
          else begin
            c = d_exp.pop_front();
            check("dl_ack", 32'(cli_dealloc_ack), 32'(1) << c);
          end
          cli_dealloc_req = cli_dealloc_req & ~cli_dealloc_ack;
        end
      end
    join_none

    // Reset state and init gating.
    do_reset();
    check_all_zero("rst");
    req_alloc(0, 0);
    seen = 1'b0;
    repeat (8) begin
      @(negedge clk);
      seen = seen | fl_alloc_req | busy;
    end
    check("init_gate", 32'(seen), 0);
    fl_init_done = 1'b1;
    lat = 0;
    while (!cli_alloc_ack[0] && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    check("alloc_latency", 32'(lat), 32'(3 + FL_LAT));
    wait_idle();

    // Fairness from pointer 0, then a wrap from pointer 3.
    do_reset();
    fl_init_done = 1'b1;
    for (int c = 0; c < int'(NCLI); c++) req_alloc(c, c);
    wait_idle();
    check("rr_ptr_end", 32'(dut.a_ptr), 0);
    req_alloc(2, 4);
    wait_idle();
    req_alloc(3, 5);
    req_alloc(0, 6);
    wait_idle();
    check("rr_ptr_wrap", 32'(dut.a_ptr), 1);

    // Dealloc id held from grant to allocator ack; single client ack.
    do_reset();
    fl_init_done = 1'b1;
    for (int c = 0; c < 3; c++) cli_dealloc_id[c*WIDTH +: WIDTH] = WIDTH'(16'hA0 + c);
    req_free(3, 5);
    lat = 0;
    while (!fl_dealloc_req && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check("dl_grant_id", 32'(fl_dealloc_id), 5);
    stable = 1'b1;
    lat = 0;
    while (!fl_dealloc_ack && lat < 20) begin
      @(negedge clk);
      lat++;
      if (fl_dealloc_id != WIDTH'(5)) stable = 1'b0;
    end
    check("dl_hold_stable", 32'(stable), 1);
    wait_idle();
    repeat (3) @(negedge clk);
    check("dl_ack_once", 32'(d_ack_cnt[3]), 1);
    check("dl_fwd_id", 32'(last_dl_id), 5);

    // Concurrent alloc (client 1) and free (client 2).
    do_reset();
    fl_init_done = 1'b1;
    req_alloc(1, 0);
    req_free(2, 7);
    ovl = 1'b0;
    lat = 0;
    while ((a_exp.size() != 0 || d_exp.size() != 0) && lat < 50) begin
      @(negedge clk);
      lat++;
      if (dut.a_st != A_IDLE && dut.d_st != D_IDLE) ovl = 1'b1;
    end
    check("overlap", 32'(ovl), 1);
    wait_idle();
    check("conc_dl_id", 32'(last_dl_id), 7);
    req_alloc(1, 1);
    wait_idle();

    // Reset asserted while both paths wait on the allocator.
    do_reset();
    fl_init_done = 1'b1;
    cli_alloc_req[0] = 1'b1;
    cli_dealloc_id[1*WIDTH +: WIDTH] = WIDTH'(9);
    cli_dealloc_req[1] = 1'b1;
    lat = 0;
    while (!(dut.a_st == A_WAIT && dut.d_st == D_WAIT) && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check("reach_wait", 32'(lat < 20), 1);
    #1;
    rst_n = 1'b0;
    #1;
    check_all_zero("rstmid");
    cli_alloc_req   = '0;
    cli_dealloc_req = '0;
    fl_init_done    = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    fl_init_done = 1'b1;
    req_alloc(2, 0);
    wait_idle();

`ifdef FLIST_ARB_QUOTA_EN
    // Quota of 2: third alloc blocked until a free, free at zero flags error.
    do_reset();
    fl_init_done = 1'b1;
    req_alloc(0, 0);
    wait_idle();
    req_alloc(0, 1);
    wait_idle();
    cli_alloc_req[0] = 1'b1;
    req_alloc(1, 2);
    wait_idle();
    seen = 1'b0;
    repeat (12) begin
      @(negedge clk);
      seen = seen | fl_alloc_req;
    end
    check("quota_block", 32'(seen), 0);
    check("quota_err_clear", 32'(quota_err), 0);
    a_exp.push_back('{cli: 0, id: 3});
    req_free(0, 0);
    wait_idle();
    req_free(3, 9);
    wait_idle();
    check("quota_err_set", 32'(quota_err), 1);
`endif

    wait_idle();
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
